// File: rtl/detect_top.sv
// Two-stage pixel pipeline: RGB to grey conversion, then threshold or pass-through.
// Each of the three output channels carries the same 8-bit result.
module detect_top #(
  parameter int unsigned PIXEL_SIZE = 23,
  parameter int unsigned THRESHOLD  = 128,
  parameter int unsigned OUT_MODE   = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                en,
  input  logic [PIXEL_SIZE:0] data,
  output logic [PIXEL_SIZE:0] out
);

  localparam int unsigned W   = PIXEL_SIZE + 1;
  localparam logic [7:0]  THR = 8'(THRESHOLD);

  logic [15:0]  sum_d;
  logic [7:0]   grey_d;
  logic [7:0]   grey_q;
  logic         v1_d;
  logic         v1_q;
  logic [7:0]   v_d;
  logic [W-1:0] out_d;
  logic [W-1:0] out_q;

  // Stage 1 combinational: weighted grey sum; 77+150+29 = 256, so the sum fits in 16 bits.
  always_comb begin
    sum_d  = 16'd77  * {8'd0, data[23:16]}
           + 16'd150 * {8'd0, data[15:8]}
           + 16'd29  * {8'd0, data[7:0]};
    grey_d = 8'(sum_d >> 8);
    v1_d   = 1'b1;
  end

  // Stage 2 combinational: binarize or pass grey, gated by the stage-1 valid flag.
  always_comb begin
    v_d   = grey_q;
    out_d = '0;
    if (OUT_MODE != 0) begin
      v_d = (grey_q >= THR) ? 8'hFF : 8'h00;
    end
    if (v1_q) begin
      out_d = W'({v_d, v_d, v_d});
    end
  end

  // Pipeline registers: reset clears everything, otherwise advance only when enabled.
  always_ff @(posedge clk) begin
    if (reset) begin
      grey_q <= '0;
      v1_q   <= 1'b0;
      out_q  <= '0;
    end else if (en) begin
      grey_q <= grey_d;
      v1_q   <= v1_d;
      out_q  <= out_d;
    end
  end

  assign out = out_q;

endmodule

// File: tb/tb_detect_top.sv
// Self-checking bench for detect_top: one instance per output mode, shared stimulus,
// expected values queued at each enabled edge and popped when they reach the output.
module tb_detect_top;

  logic        clk;
  logic        reset;
  logic        en;
  logic [23:0] data;
  logic [23:0] out0;
  logic [23:0] out1;

  int unsigned errors;
  int unsigned checks;

  logic [23:0] q0[$];
  logic [23:0] q1[$];
  logic [23:0] last0;
  logic [23:0] last1;

  detect_top #(.PIXEL_SIZE(23), .THRESHOLD(128), .OUT_MODE(0)) u_grey (
    .clk  (clk),
    .reset(reset),
    .en   (en),
    .data (data),
    .out  (out0)
  );

  detect_top #(.PIXEL_SIZE(23), .THRESHOLD(128), .OUT_MODE(1)) u_bin (
    .clk  (clk),
    .reset(reset),
    .en   (en),
    .data (data),
    .out  (out1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] grey_of(input logic [23:0] d);
    int unsigned s;
    s = 77 * int'(d[23:16]) + 150 * int'(d[15:8]) + 29 * int'(d[7:0]);
    return 8'(s / 256);
  endfunction

  function automatic logic [23:0] exp_grey(input logic [23:0] d);
    logic [7:0] g;
    g = grey_of(d);
    return {g, g, g};
  endfunction

  function automatic logic [23:0] exp_bin(input logic [23:0] d);
    return (grey_of(d) >= 8'd128) ? 24'hFFFFFF : 24'h000000;
  endfunction

  task automatic check_eq(input string tag, input logic [23:0] act, input logic [23:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Drive one clock edge, update the scoreboard, then compare both outputs.
  task automatic step(input string tag, input logic r, input logic e, input logic [23:0] d);
    reset = r;
    en    = e;
    data  = d;
    @(posedge clk);
    #1;
    if (r) begin
      q0.delete();
      q1.delete();
      last0 = '0;
      last1 = '0;
    end else if (e) begin
      if (q0.size() > 0) begin
        last0 = q0.pop_front();
        last1 = q1.pop_front();
      end
      q0.push_back(exp_grey(d));
      q1.push_back(exp_bin(d));
    end
    check_eq({tag, "_m0"}, out0, last0);
    check_eq({tag, "_m1"}, out1, last1);
  endtask

  logic [23:0] pix[8];
  logic [23:0] pa;

  initial begin
    errors = 0;
    checks = 0;
    last0  = '0;
    last1  = '0;
    reset  = 1'b1;
    en     = 1'b0;
    data   = '0;

    // Reset with en low and en high.
    step("rst_en0", 1'b1, 1'b0, 24'h123456);
    step("rst_en1", 1'b1, 1'b1, 24'hABCDEF);

    // White pixel: zero after first edge, full white after second.
    step("white_e1", 1'b0, 1'b1, 24'hFFFFFF);
    step("white_e2", 1'b0, 1'b1, 24'hFFFFFF);

    // Primary colours, black, and threshold boundary patterns.
    pix[0] = 24'hFF0000; pix[1] = 24'h00FF00; pix[2] = 24'h0000FF; pix[3] = 24'h000000;
    pix[4] = 24'h808080; pix[5] = 24'h7F7F7F; pix[6] = 24'h00FF00; pix[7] = 24'hFF0000;
    for (int i = 0; i < 8; i++) step("stream", 1'b0, 1'b1, pix[i]);
    step("stream_tail", 1'b0, 1'b1, 24'h000000);

    // Literal spot checks on the known grey values.
    step("lit_prep", 1'b0, 1'b1, 24'hFF0000);
    step("lit_red", 1'b0, 1'b1, 24'h00FF00);
    check_eq("lit_red_grey", out0, 24'h4C4C4C);
    step("lit_green", 1'b0, 1'b1, 24'h0000FF);
    check_eq("lit_green_grey", out0, 24'h959595);
    check_eq("lit_green_bin", out1, 24'hFFFFFF);
    step("lit_blue", 1'b0, 1'b1, 24'h808080);
    check_eq("lit_blue_grey", out0, 24'h1C1C1C);
    step("lit_808080", 1'b0, 1'b1, 24'h7F7F7F);
    check_eq("lit_808080_bin", out1, 24'hFFFFFF);
    step("lit_7f7f7f", 1'b0, 1'b1, 24'h000000);
    check_eq("lit_7f7f7f_bin", out1, 24'h000000);

    // Stall: pixel A held in flight while en is low and data changes.
    pa = 24'h20C040;
    step("stall_a", 1'b0, 1'b1, pa);
    for (int i = 0; i < 3; i++) step("stall_hold", 1'b0, 1'b0, 24'($urandom));
    step("stall_release", 1'b0, 1'b1, 24'h000000);
    check_eq("stall_a_out", out0, exp_grey(pa));

    // Reset mid-stream with a full pipeline; in-flight pixels must vanish.
    step("full1", 1'b0, 1'b1, 24'hFFFFFF);
    step("full2", 1'b0, 1'b1, 24'hFFFFFF);
    step("mid_rst", 1'b1, 1'b1, 24'hFFFFFF);
    check_eq("mid_rst_zero", out0, 24'h000000);
    step("post_rst1", 1'b0, 1'b1, 24'h102030);
    check_eq("post_rst1_zero", out1, 24'h000000);
    step("post_rst2", 1'b0, 1'b1, 24'h405060);

    // Continuous random stream, then a stream with random stalls.
    for (int i = 0; i < 40; i++) step("rand_stream", 1'b0, 1'b1, 24'($urandom));
    for (int i = 0; i < 60; i++) step("rand_en", 1'b0, 1'($urandom_range(0, 1)), 24'($urandom));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/detect_top.md
DETECT_TOP -- requirements
Module: detect_top

Interface
REQ-001 Parameter PIXEL_SIZE, default 23, is the MSB index of a pixel bus (pixel width = PIXEL_SIZE+1 = 24 bits).
REQ-002 Parameter THRESHOLD, default 128, is the 8-bit binarization threshold on grey level.
REQ-003 Parameter OUT_MODE, default 1, selects output: 0 = grey replicated on all channels, 1 = binary.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 en  input  1  pipeline advance enable; stage registers load only when en=1.
REQ-007 data  input  PIXEL_SIZE+1  input pixel: [7:0]=B, [15:8]=G, [23:16]=R (BMP byte order).
REQ-008 out  output  PIXEL_SIZE+1  processed pixel, same channel packing as data; driven directly from a register.

Function
REQ-009 Two-stage pipeline: S1 = grey conversion, S2 = threshold/format; each stage advances only on clk edges with en=1 and reset=0.
REQ-010 S1 computes grey = (77*R + 150*G + 29*B) >> 8 as unsigned, with a 16-bit intermediate sum (max 65280, no overflow); result is 8 bits, range 0..255.
REQ-011 S2, OUT_MODE=1: v = 8'hFF if grey >= THRESHOLD, else 8'h00; comparison inclusive at equality.
REQ-012 S2, OUT_MODE=0: v = grey.
REQ-013 out = {v, v, v}.
REQ-014 Latency: a pixel on data at en-edge k appears on out after en-edge k+1; en=0 edges do not count.
REQ-015 en=0: all stage registers and out hold their values; data is ignored that cycle.
REQ-016 A valid flag travels with each stage; out is 0 until the first pixel reaches S2.
REQ-017 X/Z on data is not filtered.
REQ-018 No combinational path from data to out.

Reset
REQ-019 reset=1 at a rising edge: all stage registers, valid flags and out become 0 on that edge, regardless of en.
REQ-020 Reset has priority over en.
REQ-021 Reset mid-stream discards all in-flight pixels.
REQ-022 After reset deasserts, the first pixel again needs two en-edges to reach out.

Verification
REQ-023 Reset, then en=1 with data=24'hFFFFFF -> out=24'h000000 after edge 1 and 24'hFFFFFF after edge 2 (both modes).
REQ-024 OUT_MODE=0, en=1; data=24'hFF0000, 24'h00FF00, 24'h0000FF, 24'h000000 on consecutive edges -> out = 24'h4C4C4C, 24'h959595, 24'h1C1C1C, 24'h000000 on consecutive edges, each after the two-edge latency.
REQ-025 OUT_MODE=1, THRESHOLD=128; data=24'h808080 -> 24'hFFFFFF; data=24'h7F7F7F -> 24'h000000; data=24'h00FF00 -> 24'hFFFFFF; data=24'hFF0000 -> 24'h000000.
REQ-026 Stall: feed pixel A, hold en=0 for 3 edges while changing data, then en=1 -> out unchanged during the stall, and A appears one en-edge after the stall ends; stall-cycle data never appears on out.
REQ-027 Reset mid-stream: assert reset for 1 edge with en=1 and pipeline full -> out=0 on the next edge; previously in-flight pixels never appear on out.
REQ-028 Continuous stream of N pixels with en=1 -> exactly N results in input order, one per edge, with no gaps or duplicates.
